// File: rtl/mp_grf_pkg.sv
// Shared defaults and constants for the multi-port register file.
package grf_pkg;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    localparam string TRACE_FMT = "%d@%h: $%d <= %h";

endpackage

// File: rtl/mp_grf_if.sv
// Read, write and issue bundle between the decode stage and the register file.
interface mp_grf_if
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned NREAD  = 2
);

    logic [NREAD*ADDR_W-1:0] r_addr;
    logic [NREAD*DATA_W-1:0] r_data;
    logic [NREAD-1:0]        r_busy;

    logic              w0_en;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic [31:0]       w0_pc;

    logic              w1_en;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic [31:0]       w1_pc;

    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;

    modport master (
        output r_addr, w0_en, w0_addr, w0_data, w0_pc,
               w1_en, w1_addr, w1_data, w1_pc, iss_en, iss_addr,
        input  r_data, r_busy
    );

    modport slave (
        input  r_addr, w0_en, w0_addr, w0_data, w0_pc,
               w1_en, w1_addr, w1_data, w1_pc, iss_en, iss_addr,
        output r_data, r_busy
    );

endinterface

// File: rtl/mp_grf_scoreboard.sv
// Per-register pending bits: writes clear, issues set, an issue beats a same-cycle clear.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int unsigned ADDR_W = GRF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en_i,
    input  logic [ADDR_W-1:0]      set_addr_i,
    input  logic                   clr0_en_i,
    input  logic [ADDR_W-1:0]      clr0_addr_i,
    input  logic                   clr1_en_i,
    input  logic [ADDR_W-1:0]      clr1_addr_i,
    output logic [(1<<ADDR_W)-1:0] pend_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr0_en_i) pend_d[clr0_addr_i] = 1'b0;
        if (clr1_en_i) pend_d[clr1_addr_i] = 1'b0;
        if (set_en_i)  pend_d[set_addr_i]  = 1'b1;
        pend_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/mp_grf.sv
// Multi-port GRF: NREAD bypassing read ports, two prioritised write ports, pending scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module mp_grf
    import grf_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned NREAD  = 2
) (
    input  logic     clk,
    input  logic     reset,
    mp_grf_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend;

    logic w0_eff_c;
    logic w1_eff_c;

    assign w0_eff_c = bus.w0_en && (bus.w0_addr != ADDR_W'(REG_ZERO));
    assign w1_eff_c = bus.w1_en && (bus.w1_addr != ADDR_W'(REG_ZERO));

    // w1 is applied last so it wins a same-address collision
    always_comb begin
        regs_d = regs_q;
        if (w0_eff_c) regs_d[bus.w0_addr] = bus.w0_data;
        if (w1_eff_c) regs_d[bus.w1_addr] = bus.w1_data;
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    grf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (bus.iss_en),
        .set_addr_i  (bus.iss_addr),
        .clr0_en_i   (w0_eff_c),
        .clr0_addr_i (bus.w0_addr),
        .clr1_en_i   (w1_eff_c),
        .clr1_addr_i (bus.w1_addr),
        .pend_o      (pend)
    );

    logic [NREAD*DATA_W-1:0] r_data_c;
    logic [NREAD-1:0]        r_busy_c;
    logic [ADDR_W-1:0]       ra_c;
    logic                    hit1_c;
    logic                    hit0_c;

    // Read bypass; a bypassed write also masks the pending bit
    always_comb begin
        r_data_c = '0;
        r_busy_c = '0;
        ra_c     = '0;
        hit1_c   = 1'b0;
        hit0_c   = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            ra_c   = bus.r_addr[k*ADDR_W +: ADDR_W];
            hit1_c = w1_eff_c && (bus.w1_addr == ra_c);
            hit0_c = w0_eff_c && (bus.w0_addr == ra_c);
            if (ra_c == ADDR_W'(REG_ZERO)) r_data_c[k*DATA_W +: DATA_W] = '0;
            else if (hit1_c)               r_data_c[k*DATA_W +: DATA_W] = bus.w1_data;
            else if (hit0_c)               r_data_c[k*DATA_W +: DATA_W] = bus.w0_data;
            else                           r_data_c[k*DATA_W +: DATA_W] = regs_q[ra_c];
            r_busy_c[k] = pend[ra_c] && !hit1_c && !hit0_c;
        end
    end

    assign bus.r_data = r_data_c;
    assign bus.r_busy = r_busy_c;

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w0_eff_c && !(w1_eff_c && (bus.w1_addr == bus.w0_addr)))
                $display("%s", $sformatf(TRACE_FMT, $time, bus.w0_pc, bus.w0_addr, bus.w0_data));
            if (w1_eff_c)
                $display("%s", $sformatf(TRACE_FMT, $time, bus.w1_pc, bus.w1_addr, bus.w1_data));
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{bus.w0_pc, bus.w1_pc};
`endif

endmodule

// File: doc/mp_grf.md
# mp_grf

Parametrised multi-port general register file for the pipelined MIPS core. It provides NREAD combinational read ports and two prioritised synchronous write ports, with internal write-to-read bypass. It also carries a per-register pending scoreboard that the decode stage uses for stall decisions. It sits in the D stage and replaces the single-write-port, non-bypassing register file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- r_addr  in  NREAD*ADDR_W  read addresses; port k occupies slice [k*ADDR_W +: ADDR_W]
- r_data  out  NREAD*DATA_W  read data; port k occupies slice [k*DATA_W +: DATA_W]
- r_busy  out  NREAD  port k's register has a pending producer
- w0_en, w1_en  in  1  write enables
- w0_addr, w1_addr  in  ADDR_W  write addresses
- w0_data, w1_data  in  DATA_W  write data
- w0_pc, w1_pc  in  32  PC of the writing instruction; used only for trace output
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination register marked pending

## Operation
- Register 0 reads as 0 and is never busy. Writes to it and issues to it are ignored.
- Write priority: when both write ports are enabled with the same address, w1 wins. w1 carries the younger result.
- Read bypass: r_data[k] comes from, in priority order:
  - 0 if the address is 0;
  - w1_data if w1_en and w1_addr match;
  - w0_data if w0_en and w0_addr match;
  - otherwise the stored value.
- Scoreboard: one pending bit per register.
  - A write on either port clears the bit for its address at the next edge.
  - iss_en sets the bit for iss_addr at the next edge.
  - When a set and a clear hit the same address in the same cycle, set wins, because the issue is a newer producer.
- r_busy[k] is the pending bit of r_addr[k]. It is masked to 0 when a write to that address is bypassed in the same cycle.
- Reset clears every register to 0 and every pending bit to 0. Reset overrides concurrent writes and issues.
- Arithmetic: no width conversion. Data is stored as-is at DATA_W bits.

## Timing
- Read latency 0: combinational from r_addr and the write ports.
- Write latency 1 edge: stored value is visible without bypass from the cycle after the edge.
- Scoreboard latency 1 edge: r_busy reflects an issue from the following cycle onward.
- Reset values: all r_data are 0 and all r_busy are 0 once the reset edge has occurred.
- Reset mid-operation discards in-flight writes and pending state. A write presented in the reset cycle is lost.

## Configuration
- GRF_TRACE_EN defined: each rising edge with reset low prints one line per effective write (wN_en and address ≠ 0).
  - Format: "%d@%h: $%d <= %h" with time, wN_pc, address, data.
  - When both ports hit the same address, only the w1 line is printed.
  - When both ports are effective with different addresses, the w0 line is printed first.
- GRF_TRACE_EN undefined: no $display in the block. The wN_pc ports remain but are unused.

## Structure
- Package grf_pkg holds:
  - default DATA_W and ADDR_W;
  - localparam REG_ZERO = 0;
  - the trace format string constant.
- Sub-module grf_scoreboard (DEPTH pending bits, set/clear logic, set-wins rule) is instantiated once.
- Storage, bypass muxes and trace logic stay in mp_grf.

## Test plan
- Reset, then read all 32 addresses on both ports -> all r_data are 0, all r_busy are 0.
- w0 writes 0x12345678 to $5; next cycle read $5 -> 0x12345678. Same-cycle read during the write -> 0x12345678 (bypass).
- w0 writes 0x1 and w1 writes 0x2 to $9 in the same cycle -> bypassed read is 0x2, stored value is 0x2, trace prints only the w1 line.
- Write 0xFFFFFFFF to $0 via w1 -> read $0 is 0, no trace line, r_busy stays 0 after iss_en on $0.
- iss_en on $7 -> r_busy=1 next cycle. w0 write to $7 plus iss_en on $7 in the same cycle -> r_busy stays 1. Then a write alone -> r_busy=0.
- Write $3=0xA, $4=0xB, then assert reset in the same cycle as a w0 write of 0xC to $3 -> after reset, $3, $4 and all pending bits read 0.
